// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 keyboard receiver.
//
// Oversamples the raw PS/2 clock and data lines in the system clock domain.
// It deserialises 11-bit device-to-host frames and queues valid scan-code bytes
// in a small FIFO, which the consumer drains with an active-low pop strobe.
//
// Ports:
//   clk        - system clock, rising-edge active
//   clrn       - asynchronous reset, active HIGH despite the name
//   ps2_clk    - raw PS/2 clock from the keyboard (asynchronous)
//   ps2_data   - raw PS/2 data from the keyboard (asynchronous)
//   nextdata_n - pop strobe, active low, sampled at the clk rising edge
//   data       - byte at the FIFO head (stale storage when empty)
//   ready      - FIFO is non-empty
//   overflow   - sticky: a valid frame was dropped because the FIFO was full;
//                cleared by any pop
module ps2_keyboard #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  logic [2:0]      sync_q, sync_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [9:0]      shift_q, shift_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;

  logic fall;
  logic frame_ok;
  logic push;
  logic pop;
  logic full;
  logic push_acc;

  // Falling edge seen on the two oldest synchroniser stages; the newest stage
  // only absorbs metastability.
  assign fall = sync_q[2] & ~sync_q[1];

  // When bit 10 arrives, shift_q holds the start bit in [0], the data bits
  // in [8:1], and parity in [9]. Odd parity: the XOR of data and parity is 1.
  assign frame_ok = (shift_q[0] == 1'b0) && ps2_data && (^shift_q[9:1]);
  assign push     = fall && (bit_cnt_q == 4'd10) && frame_ok;
  assign pop      = ~nextdata_n && (count_q != '0);
  assign full     = (count_q == FullCnt);
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign push_acc = push && (!full || pop);

  // Synchroniser and deserialiser.
  always_comb begin
    sync_d    = {sync_q[1:0], ps2_clk};
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (fall) begin
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
      end else begin
        shift_d[bit_cnt_q] = ps2_data;
        bit_cnt_d          = bit_cnt_q + 4'd1;
      end
    end
  end

  // FIFO next state.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push_acc) begin
      mem_d[wr_ptr_q] = shift_q[8:1];
      wr_ptr_d        = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end

    if (push_acc && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push_acc) begin
      count_d = count_q - CntW'(1);
    end

    if (pop) begin
      overflow_d = 1'b0;
    end else if (push && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      sync_q     <= 3'b111;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 10'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      sync_q     <= sync_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  assign data     = mem_q[rd_ptr_q];
  assign ready    = (count_q != '0);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Testbench for ps2_keyboard.
//
// The stimulus process drives PS/2 frames. For every well-formed frame, the
// reference model queues the expected byte, or records a drop when 8 bytes
// are already waiting. A separate monitor process compares the head byte on
// every cycle in which the DUT pops.
module tb_ps2_keyboard;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Reference model: bytes expected out of the FIFO, and the sticky drop flag.
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;

  ps2_keyboard #(.FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a pop happens at the next rising edge.
  always @(negedge clk) begin
    if (!clrn && ready && !nextdata_n) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected: got %02h, expected no byte at %0t", data, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data !== e) begin
          failures++;
          $display("FAIL pop_data: got %02h, expected %02h at %0t", data, e, $time);
        end
      end
      exp_ovf = 1'b0;
    end
  end

  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() < 8) exp_q.push_back(b);
    else exp_ovf = 1'b1;
  endtask

  task automatic check_state(input string name);
    check({name, "_ready"}, {7'd0, ready}, {7'd0, exp_q.size() != 0});
    check({name, "_ovf"}, {7'd0, overflow}, {7'd0, exp_ovf});
  endtask

  // Sends one 11-bit frame. The model is updated before the stop-bit edge so
  // that a pop held low can consume the byte as soon as it appears.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit bad_start);
    logic [10:0] f;
    bit          valid;
    f[0]    = bad_start;
    f[8:1]  = b;
    f[9]    = ~(^b) ^ bad_par;
    f[10]   = ~bad_stop;
    valid   = !(bad_par || bad_stop || bad_start);
    for (int i = 0; i < 11; i++) begin
      ps2_data = f[i];
      #43;
      if (i == 10 && valid) model_push(b);
      ps2_clk = 1'b0;
      if (i < 10) begin
        #80;
        ps2_clk = 1'b1;
        #37;
      end
    end
    // The byte must be visible within 4 clk of the last falling edge.
    repeat (4) @(posedge clk);
    #1;
    if (nextdata_n) begin
      check("latency_ready", {7'd0, ready}, {7'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) check("latency_data", data, exp_q[0]);
    end
    #40;
    ps2_clk  = 1'b1;
    #40;
    ps2_data = 1'b1;
    #40;
  endtask

  // Sends only the first n bits of a frame and leaves ps2_clk high.
  task automatic send_partial(input logic [7:0] b, input int n);
    logic [10:0] f;
    f = {1'b1, ~(^b), b, 1'b0};
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      #43;
      ps2_clk = 1'b0;
      #80;
      ps2_clk = 1'b1;
      #37;
    end
  endtask

  task automatic pop_one();
    @(posedge clk);
    #1 nextdata_n = 1'b0;
    @(posedge clk);
    #1 nextdata_n = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 clrn = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {7'd0, ready}, 8'h00);
    check("rst_ovf", {7'd0, overflow}, 8'h00);
    check("rst_data", data, 8'h00);
    #2 clrn = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [7:0] seq[3];
    int         npop;
    int         r;

    repeat (3) @(posedge clk);
    do_reset();

    // Single byte.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check("single_ready", {7'd0, ready}, 8'h01);
    check("single_data", data, 8'h1C);
    pop_one();
    check_state("single_after_pop");

    // Bad frames.
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    check_state("bad_parity");
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    check_state("bad_stop");
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    check_state("bad_start");

    // Ordering.
    seq = '{8'hF0, 8'h1C, 8'h5A};
    for (int i = 0; i < 3; i++) send_frame(seq[i], 1'b0, 1'b0, 1'b0);
    check("order_head", data, 8'hF0);
    for (int i = 0; i < 3; i++) pop_one();
    check_state("order_drained");

    // Overflow: the ninth byte is lost.
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 8) check("ovf_after8", {7'd0, overflow}, 8'h00);
      if (i == 9) check("ovf_after9", {7'd0, overflow}, 8'h01);
    end
    pop_one();
    check("ovf_cleared", {7'd0, overflow}, 8'h00);
    for (int i = 0; i < 7; i++) pop_one();
    check_state("ovf_drained");

    // Reset in the middle of a frame.
    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    send_partial(8'h77, 5);
    do_reset();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    check("midrst_ready", {7'd0, ready}, 8'h01);
    check("midrst_data", data, 8'h5A);
    pop_one();

    // Pop held low while empty: the byte is consumed as soon as it lands.
    @(posedge clk);
    #1 nextdata_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("emptypop_ready", {7'd0, ready}, 8'h00);
    send_frame(8'h2B, 1'b0, 1'b0, 1'b0);
    #1;
    check("emptypop_consumed", {7'd0, ready}, 8'h00);
    check("emptypop_model", 8'(exp_q.size()), 8'h00);
    @(posedge clk);
    #1 nextdata_n = 1'b1;

    // Randomised traffic with occasional corruption and bursts of pops.
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 7));
      send_frame(8'($urandom), r == 0, r == 1, r == 2);
      check_state("rand");
      npop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      for (int k = 0; k < npop; k++) pop_one();
    end

    // Drain with a bounded number of pops.
    for (int k = 0; k < 10 && ready; k++) pop_one();
    check_state("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog.
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
